// File: rtl/particle_ram_arbiter_pkg.sv
// Shared types for the particle RAM arbiter.
// Clear FSM encoding and requester count.
package particle_ram_arbiter_pkg;

  localparam int N_REQ = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/particle_ram_arbiter_rr_arbiter2.sv
// Two-way round-robin picker.
// The priority bit only moves when the parent accepts the pick.
module rr_arbiter2
  import particle_ram_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] pick
);

  logic prio;

  always_comb begin
    pick = '0;
    unique case (1'b1)
      (req == 2'b11): pick = prio ? 2'b10 : 2'b01;
      (req == 2'b01): pick = 2'b01;
      (req == 2'b10): pick = 2'b10;
      default:        pick = '0;
    endcase
  end

  // favour the requester that did not just win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (accept && |pick) begin
      prio <= pick[0];
    end
  end

endmodule

// File: rtl/particle_ram_arbiter.sv
// Read/write arbiter in front of a dual-port block RAM,
// with a whole-RAM zero-fill sequencer.
module particle_ram_arbiter
  import particle_ram_arbiter_pkg::*;
#(
  parameter int data_width = 16,
  parameter int addr_width = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_start,
  output logic                      clear_busy,
  input  logic [N_REQ-1:0]          rd_req,
  input  logic [2*addr_width-1:0]   rd_addr,
  output logic [N_REQ-1:0]          rd_gnt,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [data_width-1:0]     rd_data,
  input  logic [N_REQ-1:0]          wr_req,
  input  logic [2*addr_width-1:0]   wr_addr,
  input  logic [2*data_width-1:0]   wr_data,
  output logic [N_REQ-1:0]          wr_gnt,
  output logic [addr_width-1:0]     ram_raddr,
  input  logic [data_width-1:0]     ram_dout,
  output logic [addr_width-1:0]     ram_waddr,
  output logic [data_width-1:0]     ram_din,
  output logic                      ram_write_en
);

  clr_state_t            state;
  logic [addr_width-1:0] clr_cnt;
  logic [N_REQ-1:0]      rd_pick;
  logic [N_REQ-1:0]      wr_pick;
  logic [addr_width-1:0] rd_sel_addr;
  logic [addr_width-1:0] wr_sel_addr;
  logic [data_width-1:0] wr_sel_data;
  logic                  collide;

  assign clear_busy = (state == CLEAR);

  assign rd_sel_addr = rd_pick[1] ? rd_addr[2*addr_width-1:addr_width]
                                  : rd_addr[addr_width-1:0];
  assign wr_sel_addr = wr_pick[1] ? wr_addr[2*addr_width-1:addr_width]
                                  : wr_addr[addr_width-1:0];
  assign wr_sel_data = wr_pick[1] ? wr_data[2*data_width-1:data_width]
                                  : wr_data[data_width-1:0];

  assign wr_gnt       = clear_busy ? '0 : wr_pick;
  assign ram_write_en = clear_busy | (|wr_gnt);
  assign ram_waddr    = clear_busy ? clr_cnt : wr_sel_addr;
  assign ram_din      = clear_busy ? '0 : wr_sel_data;

  // write wins a same-address clash; the read retries next cycle
  assign collide = ram_write_en && (|rd_pick) && (rd_sel_addr == ram_waddr);

  assign rd_gnt    = collide ? '0 : rd_pick;
  assign ram_raddr = rd_sel_addr;
  assign rd_data   = ram_dout;

  rr_arbiter2 u_rd_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (rd_req),
    .accept (!collide),
    .pick   (rd_pick)
  );

  rr_arbiter2 u_wr_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (wr_req),
    .accept (!clear_busy),
    .pick   (wr_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          clr_cnt <= '0;
          if (clear_start) state <= CLEAR;
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_particle_ram_arbiter.sv
// Bench for particle_ram_arbiter with a behavioural RAM,
// read scoreboard and per-scenario tasks.
module tb_particle_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic            clk;
  logic            rst_n;
  logic            clear_start;
  logic            clear_busy;
  logic [1:0]      rd_req;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]      rd_gnt;
  logic [1:0]      rd_valid;
  logic [DW-1:0]   rd_data;
  logic [1:0]      wr_req;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [1:0]      wr_gnt;
  logic [AW-1:0]   ram_raddr;
  logic [DW-1:0]   ram_dout;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_din;
  logic            ram_write_en;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   shadow [DEPTH];
  logic [DW+1:0]   sb [$];
  int              n_tests;
  int              n_fail;

  particle_ram_arbiter #(.data_width(DW), .addr_width(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt),
    .ram_raddr    (ram_raddr),
    .ram_dout     (ram_dout),
    .ram_waddr    (ram_waddr),
    .ram_din      (ram_din),
    .ram_write_en (ram_write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (rst_n && rd_valid != 2'b00) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: valid=%b data=%h, none expected",
                 rd_valid, rd_data);
      end else begin
        e = sb.pop_front();
        if (rd_valid !== e[DW+1:DW] || rd_data !== e[DW-1:0]) begin
          n_fail++;
          $display("FAIL rd_data: valid=%b data=%h, expected valid=%b data=%h",
                   rd_valid, rd_data, e[DW+1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic do_write(input int id, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    logic [1:0] oh;
    int n;
    oh = (id == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    wr_req[id] = 1'b1;
    wr_addr[id*AW +: AW] = a;
    wr_data[id*DW +: DW] = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (wr_gnt === oh) break;
      n++;
      if (n > 8) break;
    end
    n_tests++;
    if (wr_gnt !== oh || ram_waddr !== a || ram_din !== d || ram_write_en !== 1'b1) begin
      n_fail++;
      $display("FAIL write_%0d: gnt=%b waddr=%h din=%h, expected gnt=%b waddr=%h din=%h",
               id, wr_gnt, ram_waddr, ram_din, oh, a, d);
    end
    shadow[a] = d;
    @(posedge clk); #1;
    wr_req[id] = 1'b0;
  endtask

  task automatic do_read(input int id, input logic [AW-1:0] a);
    logic [1:0] oh;
    int n;
    oh = (id == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    rd_req[id] = 1'b1;
    rd_addr[id*AW +: AW] = a;
    n = 0;
    forever begin
      @(negedge clk);
      if (rd_gnt === oh) break;
      n++;
      if (n > 8) break;
    end
    n_tests++;
    if (rd_gnt !== oh || ram_raddr !== a) begin
      n_fail++;
      $display("FAIL read_gnt_%0d: gnt=%b raddr=%h, expected gnt=%b raddr=%h",
               id, rd_gnt, ram_raddr, oh, a);
    end else begin
      sb.push_back({oh, shadow[a]});
    end
    @(posedge clk); #1;
    rd_req[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_start = 1'b0;
    rd_req = '0;
    rd_addr = '0;
    wr_req = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (clear_busy !== 1'b0 || rd_valid !== 2'b00 || ram_write_en !== 1'b0 ||
        rd_gnt !== 2'b00 || wr_gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL reset: busy=%b valid=%b we=%b rg=%b wg=%b, expected all 0",
               clear_busy, rd_valid, ram_write_en, rd_gnt, wr_gnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_rr();
    logic [1:0] exp [4];
    exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b10;
    @(posedge clk); #1;
    wr_req = 2'b11;
    wr_addr = {4'd2, 4'd1};
    wr_data = {16'hB222, 16'hA111};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (wr_gnt !== exp[i]) begin
        n_fail++;
        $display("FAIL write_rr[%0d]: gnt=%b, expected %b", i, wr_gnt, exp[i]);
      end
    end
    @(posedge clk); #1;
    wr_req = 2'b00;
    shadow[1] = 16'hA111;
    shadow[2] = 16'hB222;
  endtask

  task automatic test_single_read();
    do_write(0, 4'd5, 16'h1234);
    @(posedge clk); #1;
    rd_req[0] = 1'b1;
    rd_addr[AW-1:0] = 4'd5;
    @(negedge clk);
    n_tests++;
    if (rd_gnt !== 2'b01 || ram_raddr !== 4'd5) begin
      n_fail++;
      $display("FAIL single_read_gnt: gnt=%b raddr=%h, expected 01/5", rd_gnt, ram_raddr);
    end
    sb.push_back({2'b01, 16'h1234});
    @(posedge clk); #1;
    rd_req[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_valid !== 2'b01 || rd_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_read_data: valid=%b data=%h, expected 01/1234",
               rd_valid, rd_data);
    end
  endtask

  task automatic test_read_rr();
    @(posedge clk); #1;
    rd_req = 2'b11;
    rd_addr = {4'd2, 4'd1};
    @(negedge clk);
    n_tests++;
    if (rd_gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL read_rr_first: gnt=%b, expected 10", rd_gnt);
    end else sb.push_back({2'b10, shadow[2]});
    @(posedge clk); #1;
    rd_req[1] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL read_rr_second: gnt=%b, expected 01", rd_gnt);
    end else sb.push_back({2'b01, shadow[1]});
    @(posedge clk); #1;
    rd_req = 2'b00;
  endtask

  task automatic test_collision();
    @(posedge clk); #1;
    wr_req[1] = 1'b1;
    wr_addr[2*AW-1:AW] = 4'd7;
    wr_data[2*DW-1:DW] = 16'hBEEF;
    rd_req[0] = 1'b1;
    rd_addr[AW-1:0] = 4'd7;
    @(negedge clk);
    n_tests++;
    if (rd_gnt !== 2'b00 || wr_gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL collision: rg=%b wg=%b, expected 00/10", rd_gnt, wr_gnt);
    end
    shadow[7] = 16'hBEEF;
    @(posedge clk); #1;
    wr_req[1] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL collision_retry: rg=%b, expected 01", rd_gnt);
    end else sb.push_back({2'b01, 16'hBEEF});
    @(posedge clk); #1;
    rd_req[0] = 1'b0;
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < DEPTH; i++) do_write(i % 2, 4'(i), 16'hA000 + 16'(i));
    @(posedge clk); #1;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    wr_req[0] = 1'b1;
    wr_addr[AW-1:0] = 4'd3;
    wr_data[DW-1:0] = 16'h5A5A;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!clear_busy) break;
      n++;
      n_tests++;
      if (wr_gnt !== 2'b00 || ram_write_en !== 1'b1 || ram_din !== 16'h0) begin
        n_fail++;
        $display("FAIL clear_cycle[%0d]: wg=%b we=%b din=%h, expected 00/1/0",
                 n, wr_gnt, ram_write_en, ram_din);
      end
      clear_start = (n == 5);
    end
    clear_start = 1'b0;
    n_tests++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL clear_len: busy cycles=%0d, expected %0d", n, DEPTH);
    end
    n_tests++;
    if (wr_gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL clear_release: wg=%b, expected 01", wr_gnt);
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    shadow[3] = 16'h5A5A;
    @(posedge clk); #1;
    wr_req[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_read(i % 2, 4'(i));
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int i = 0; i < DEPTH; i++) do_write(0, 4'(i), 16'h0100 + 16'(i));
    @(posedge clk); #1;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (clear_busy && ram_waddr == 4'd6) break;
      n++;
      if (n > 30) break;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (clear_busy !== 1'b0 || ram_write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b we=%b, expected 0/0", clear_busy, ram_write_en);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (clear_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_resume[%0d]: busy=%b, expected 0", i, clear_busy);
      end
    end
    for (int i = 0; i < 6; i++) shadow[i] = '0;
    for (int i = 0; i < DEPTH; i++) do_read(1, 4'(i));
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_write_rr();
    test_single_read();
    test_read_rr();
    test_collision();
    test_clear();
    test_reset_mid_clear();
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/particle_ram_arbiter.md
PARTICLE_RAM_ARBITER -- requirements
Module: particle_ram_arbiter

Interface
REQ-001 Parameter data_width, default 16, RAM word width.
REQ-002 Parameter addr_width, default 10, RAM address width (depth 2**addr_width).
REQ-003 clk  in  1  single clock; drives both wclk and rclk of the attached dual_port_block_ram.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 clear_start  in  1  one-cycle pulse requesting a zero-fill of the whole RAM.
REQ-006 clear_busy  out  1  high while a zero-fill is in progress.
REQ-007 rd_req  in  2  per-requester read request, held until granted.
REQ-008 rd_addr  in  2*addr_width  per-requester read address (requester i in slice i).
REQ-009 rd_gnt  out  2  per-requester read grant, same cycle as acceptance.
REQ-010 rd_valid  out  2  per-requester read data valid, one cycle after rd_gnt.
REQ-011 rd_data  out  data_width  read data, shared, qualified by rd_valid.
REQ-012 wr_req  in  2  per-requester write request, held until granted.
REQ-013 wr_addr  in  2*addr_width  per-requester write address.
REQ-014 wr_data  in  2*data_width  per-requester write data.
REQ-015 wr_gnt  out  2  per-requester write grant; write committed at that clock edge.
REQ-016 ram_raddr  out  addr_width  to RAM raddr.
REQ-017 ram_dout  in  data_width  from RAM dout (registered, 1-cycle latency).
REQ-018 ram_waddr  out  addr_width  to RAM waddr.
REQ-019 ram_din  out  data_width  to RAM din.
REQ-020 ram_write_en  out  1  to RAM write_en.

Function
REQ-021 Read and write ports SHALL be arbitrated independently, each granting at most one requester per cycle.
REQ-022 Grants SHALL be combinational from requests and a registered priority bit per port; at most one bit of rd_gnt and of wr_gnt is high.
REQ-023 Round-robin: when both request, the requester not granted last on that port SHALL win; the priority bit updates only on a grant.
REQ-024 A single requester SHALL be granted in the same cycle it requests, absent the conditions of REQ-027/REQ-028.
REQ-025 ram_raddr SHALL equal the granted rd_addr slice; rd_valid[i] SHALL be a registered copy of rd_gnt[i]; rd_data SHALL equal ram_dout.
REQ-026 ram_write_en SHALL equal |wr_gnt (or clear write); ram_waddr/ram_din SHALL equal the granted slices.
REQ-027 Read/write collision: if the granted read address equals the granted write address in the same cycle, rd_gnt SHALL be held low that cycle (write wins, read retried next cycle).
REQ-028 Clear FSM states IDLE, CLEAR: IDLE->CLEAR on clear_start; CLEAR writes 0 to address counter, incrementing each cycle; CLEAR->IDLE after writing address 2**addr_width-1.
REQ-029 During CLEAR, wr_gnt SHALL stay 0 and ram_write_en SHALL be 1 every cycle; reads continue to be arbitrated (collision rule applies vs. clear address).
REQ-030 clear_start SHALL be ignored while clear_busy is high; clear_busy SHALL equal (state==CLEAR).
REQ-031 Address counter SHALL be addr_width bits and wrap to 0 on exit.

Reset
REQ-032 On rst_n low: state IDLE, counter 0, both priority bits favour requester 0, rd_valid 0, clear_busy 0, ram_write_en 0.
REQ-033 Reset asserted mid-CLEAR SHALL abort the fill; no resume after release.

Structure
REQ-034 FSM state encoding and requester-count constant SHALL live in a shared package.
REQ-035 One sub-module, rr_arbiter2 (2-way round-robin with priority register), SHALL be instantiated twice, once per port.

Verification
REQ-036 Req0 reads addr 5 alone (RAM preloaded 5->0x1234) -> rd_gnt=01 same cycle, rd_valid=01 and rd_data=0x1234 next cycle.
REQ-037 Both requesters assert wr_req continuously for 4 cycles -> wr_gnt sequence 01,10,01,10.
REQ-038 Write addr 7 (req1) and read addr 7 (req0) same cycle -> rd_gnt=00, then rd_gnt=01 next cycle returning the new data.
REQ-039 clear_start pulse, addr_width=4 -> clear_busy high exactly 16 cycles, all 16 words read back 0, wr_req ignored throughout.
REQ-040 rst_n low at clear counter 6 -> clear_busy 0 immediately, words 6..15 keep prior contents.
